// File: rtl/arb_burst_mux.sv
// Burst mover behind the two-client arbiter: forwards one BURST_LEN-beat burst
// from the granted client to a shared valid/ready sink, with done/abort pulses.
module arb_burst_mux #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] data_0,
  output logic              take_0,
  input  logic              valid_1,
  input  logic [DATA_W-1:0] data_1,
  output logic              take_1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready,
  output logic              done_0,
  output logic              done_1,
  output logic              abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [7:0] STALL_LIM  = 8'(TIMEOUT - 1);
  localparam bit         TIMEOUT_EN = (TIMEOUT != 0);

  state_t     state, next_state;
  logic       owner, next_owner;
  logic [7:0] beat_cnt, next_beat_cnt;
  logic [7:0] stall_cnt, next_stall_cnt;
  logic       set_done, set_abort;

  logic in_xfer;
  logic owner_gnt;
  logic owner_valid;
  logic beat;

  // Datapath stays combinational so a word moves in the same cycle it is offered.
  always_comb begin
    in_xfer     = (state == XFER);
    owner_gnt   = owner ? gnt_1 : gnt_0;
    owner_valid = owner ? valid_1 : valid_0;
    // Grant loss suppresses the beat, so it wins over both a transfer and the timeout.
    out_valid   = in_xfer & owner_gnt & owner_valid;
    beat        = out_valid & out_ready;
    take_0      = beat & ~owner;
    take_1      = beat & owner;
    out_data    = in_xfer ? (owner ? data_1 : data_0) : '0;
    out_last    = in_xfer && (beat_cnt == LAST_BEAT);
    out_src     = owner;
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    next_state     = state;
    next_owner     = owner;
    next_beat_cnt  = beat_cnt;
    next_stall_cnt = stall_cnt;
    set_done       = 1'b0;
    set_abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_0 || gnt_1) begin
          next_owner     = ~gnt_0;
          next_beat_cnt  = 8'd0;
          next_stall_cnt = 8'd0;
          next_state     = XFER;
        end
      end
      XFER: begin
        if (!owner_gnt) begin
          next_state = IDLE;
          set_abort  = 1'b1;
        end else if (beat) begin
          next_beat_cnt  = beat_cnt + 8'd1;
          next_stall_cnt = 8'd0;
          if (beat_cnt == LAST_BEAT) begin
            next_state = DONE;
            set_done   = 1'b1;
          end
        end else begin
          next_stall_cnt = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
          if (TIMEOUT_EN && (stall_cnt == STALL_LIM)) begin
            next_state = IDLE;
            set_abort  = 1'b1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      beat_cnt  <= 8'd0;
      stall_cnt <= 8'd0;
      done_0    <= 1'b0;
      done_1    <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= next_state;
      owner     <= next_owner;
      beat_cnt  <= next_beat_cnt;
      stall_cnt <= next_stall_cnt;
      done_0    <= set_done & ~owner;
      done_1    <= set_done & owner;
      abort     <= set_abort;
    end
  end

endmodule

// File: tb/tb_arb_burst_mux.sv
// Directed bench for arb_burst_mux: default build plus a BURST_LEN=1 build
// sharing the same client/sink stimulus.
module tb_arb_burst_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic       gnt_0, gnt_1, valid_0, valid_1, out_ready;
  logic [7:0] data_0, data_1;

  logic       take_0, take_1, out_valid, out_last, out_src, done_0, done_1, abort;
  logic [7:0] out_data;
  logic       s_take_0, s_take_1, s_out_valid, s_out_last, s_out_src, s_done_0, s_done_1, s_abort;
  logic [7:0] s_out_data;

  int n_checks = 0;
  int n_pass   = 0;
  int takes;

  always #5 clk = ~clk;

  arb_burst_mux #(.DATA_W(8), .BURST_LEN(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .valid_0(valid_0), .data_0(data_0), .take_0(take_0),
    .valid_1(valid_1), .data_1(data_1), .take_1(take_1),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready),
    .done_0(done_0), .done_1(done_1), .abort(abort)
  );

  arb_burst_mux #(.DATA_W(8), .BURST_LEN(1), .TIMEOUT(16)) dut1 (
    .clk(clk), .reset(reset), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .valid_0(valid_0), .data_0(data_0), .take_0(s_take_0),
    .valid_1(valid_1), .data_1(data_1), .take_1(s_take_1),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last),
    .out_src(s_out_src), .out_ready(out_ready),
    .done_0(s_done_0), .done_1(s_done_1), .abort(s_abort)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; gnt_0 = 0; gnt_1 = 0; valid_0 = 0; valid_1 = 0;
    out_ready = 0; data_0 = 8'h00; data_1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_outs", 32'({take_0, take_1, out_last, out_src, done_0, done_1, abort}), 0);
    check("rst_out_data", 32'(out_data), 0);
    reset = 1'b0;

    // Test 1: client 0, ready always high, four back-to-back beats.
    gnt_0 = 1; valid_0 = 1; out_ready = 1; data_0 = 8'h10; takes = 0;
    @(negedge clk);
    check("t1_idle_valid", 32'(out_valid), 0);
    check("t1_idle_take", 32'(take_0), 0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      data_0 = 8'(8'h10 + i);
      @(negedge clk);
      check("t1_valid", 32'(out_valid), 1);
      check("t1_data", 32'(out_data), 32'(8'h10 + i));
      check("t1_last", 32'(out_last), 32'(i == 3));
      check("t1_take0", 32'(take_0), 1);
      check("t1_take1", 32'(take_1), 0);
      check("t1_src", 32'(out_src), 0);
      next_cycle();
    end
    gnt_0 = 0; valid_0 = 0;
    @(negedge clk);
    check("t1_done0", 32'(done_0), 1);
    check("t1_done1", 32'(done_1), 0);
    check("t1_done_valid", 32'(out_valid), 0);
    next_cycle();
    @(negedge clk);
    check("t1_done0_clear", 32'(done_0), 0);
    check("t1_abort", 32'(abort), 0);
    next_cycle();

    // Test 2: client 1, ready toggling 1,0,1,... -> 4 beats over 7 cycles.
    gnt_1 = 1; valid_1 = 1; data_1 = 8'hA0; takes = 0;
    @(negedge clk);
    check("t2_idle_valid", 32'(out_valid), 0);
    next_cycle();
    for (int k = 0, b = 0; k < 7; k++) begin
      out_ready = (k % 2 == 0);
      data_1 = 8'(8'hA0 + b);
      @(negedge clk);
      check("t2_valid", 32'(out_valid), 1);
      check("t2_data", 32'(out_data), 32'(8'hA0 + b));
      check("t2_last", 32'(out_last), 32'(b == 3));
      check("t2_take1", 32'(take_1), 32'(k % 2 == 0));
      check("t2_take0", 32'(take_0), 0);
      check("t2_src", 32'(out_src), 1);
      if (take_1) takes++;
      if (k % 2 == 0) b++;
      next_cycle();
    end
    check("t2_take_count", 32'(takes), 4);
    gnt_1 = 0; valid_1 = 0; out_ready = 1;
    @(negedge clk);
    check("t2_done1", 32'(done_1), 1);
    check("t2_done0", 32'(done_0), 0);
    next_cycle();
    @(negedge clk);
    check("t2_done1_clear", 32'(done_1), 0);
    next_cycle();

    // Test 3: grant withdrawn after two beats.
    gnt_0 = 1; valid_0 = 1; out_ready = 1; takes = 0;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      data_0 = 8'(8'h20 + i);
      @(negedge clk);
      check("t3_data", 32'(out_data), 32'(8'h20 + i));
      if (take_0) takes++;
      next_cycle();
    end
    gnt_0 = 0; data_0 = 8'h22;
    @(negedge clk);
    check("t3_drop_valid", 32'(out_valid), 0);
    check("t3_drop_take", 32'(take_0), 0);
    if (take_0) takes++;
    next_cycle();
    valid_0 = 0;
    @(negedge clk);
    check("t3_abort", 32'(abort), 1);
    check("t3_done0", 32'(done_0), 0);
    next_cycle();
    @(negedge clk);
    check("t3_abort_clear", 32'(abort), 0);
    check("t3_take_count", 32'(takes), 2);
    next_cycle();

    // Test 4: source stalls, timeout after 16 stalled cycles.
    gnt_1 = 1; valid_1 = 0; out_ready = 1;
    next_cycle();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t4_stall_valid", 32'(out_valid), 0);
      check("t4_no_early_abort", 32'(abort), 0);
      next_cycle();
    end
    gnt_1 = 0;
    @(negedge clk);
    check("t4_abort", 32'(abort), 1);
    check("t4_done1", 32'(done_1), 0);
    next_cycle();
    @(negedge clk);
    check("t4_abort_clear", 32'(abort), 0);
    next_cycle();

    // Test 5: both grants high -> client 0 wins; reset mid-burst.
    gnt_0 = 1; gnt_1 = 1; valid_0 = 1; valid_1 = 1; data_0 = 8'h30; data_1 = 8'h55;
    next_cycle();
    @(negedge clk);
    check("t5_src", 32'(out_src), 0);
    check("t5_data", 32'(out_data), 32'h30);
    check("t5_take0", 32'(take_0), 1);
    check("t5_take1", 32'(take_1), 0);
    next_cycle();
    data_0 = 8'h31;
    #1;
    check("t5_pre_reset_valid", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(out_valid), 0);
    check("t5_async_outs", 32'({take_0, take_1, out_last, out_src, done_0, done_1, abort}), 0);
    check("t5_async_data", 32'(out_data), 0);
    gnt_0 = 0; gnt_1 = 0; valid_0 = 0; valid_1 = 0;
    @(negedge clk);
    check("t5_no_pulse", 32'({done_0, done_1, abort, s_done_0, s_abort}), 0);
    next_cycle();
    reset = 1'b0;

    // Test 6: BURST_LEN=1 build.
    gnt_0 = 1; valid_0 = 1; out_ready = 0; data_0 = 8'h40;
    @(negedge clk);
    check("t6_idle_valid", 32'(s_out_valid), 0);
    next_cycle();
    @(negedge clk);
    check("t6_stall_valid", 32'(s_out_valid), 1);
    check("t6_stall_last", 32'(s_out_last), 1);
    check("t6_stall_take", 32'(s_take_0), 0);
    next_cycle();
    out_ready = 1;
    @(negedge clk);
    check("t6_beat_last", 32'(s_out_last), 1);
    check("t6_beat_take", 32'(s_take_0), 1);
    check("t6_beat_data", 32'(s_out_data), 32'h40);
    next_cycle();
    data_0 = 8'h41;
    @(negedge clk);
    check("t6_done0", 32'(s_done_0), 1);
    check("t6_done_valid", 32'(s_out_valid), 0);
    next_cycle();
    @(negedge clk);
    check("t6_gap_valid", 32'(s_out_valid), 0);
    check("t6_done0_clear", 32'(s_done_0), 0);
    next_cycle();
    @(negedge clk);
    check("t6_next_valid", 32'(s_out_valid), 1);
    check("t6_next_data", 32'(s_out_data), 32'h41);
    check("t6_next_last", 32'(s_out_last), 1);
    check("t6_next_take", 32'(s_take_0), 1);
    gnt_0 = 0; valid_0 = 0;
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_burst_mux.md
Name: arb_burst_mux

Overview:
- Downstream stage of the two-client arbiter: consumes gnt_0/gnt_1 and moves one fixed-length burst from the granted client to a single shared sink over a valid/ready handshake.
- Pulses a per-client done when the burst completes, so the client drops its req.
- Aborts the burst if the grant is withdrawn early or the source stalls past a timeout.

Parameters:
- DATA_W, 8, width of client and sink data words.
- BURST_LEN, 4, beats per burst; legal range 1..255.
- TIMEOUT, 16, maximum consecutive stalled cycles in XFER before abort; 0 disables the timeout; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- gnt_0  input  1  grant to client 0, from the arbiter.
- gnt_1  input  1  grant to client 1, from the arbiter.
- valid_0  input  1  client 0 has a word on data_0.
- data_0  input  DATA_W  client 0 data word.
- take_0  output  1  client 0 word consumed this cycle.
- valid_1  input  1  client 1 has a word on data_1.
- data_1  input  DATA_W  client 1 data word.
- take_1  output  1  client 1 word consumed this cycle.
- out_valid  output  1  sink word valid.
- out_data  output  DATA_W  sink word.
- out_last  output  1  current beat is the final beat of the burst.
- out_src  output  1  owner of the current burst (0 or 1).
- out_ready  input  1  sink accepts a word.
- done_0  output  1  one-cycle pulse: client 0 burst complete.
- done_1  output  1  one-cycle pulse: client 1 burst complete.
- abort  output  1  one-cycle pulse: burst terminated early.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, owner=0, beat_cnt=0, stall_cnt=0.
  - All outputs 0.
- FSM states: IDLE, XFER, DONE. State, owner, beat_cnt, stall_cnt and the done/abort pulses are registered.
- IDLE:
  - gnt_0=1: owner<=0, beat_cnt<=0, stall_cnt<=0, go XFER.
  - Else gnt_1=1: owner<=1, same clears, go XFER.
  - Both grants high (arbiter protocol violation): client 0 wins.
  - No beats transfer in IDLE: out_valid=0, take_n=0.
- XFER, combinational datapath:
  - out_valid = valid_owner.
  - out_data = data_owner.
  - out_src = owner.
  - out_last = (beat_cnt==BURST_LEN-1).
  - take_owner = out_valid & out_ready.
  - take of the non-owner = 0.
- Beat: a cycle with out_valid & out_ready.
  - On a beat: beat_cnt increments and stall_cnt clears.
  - On the last beat: go DONE.
- Stall: a cycle in XFER without a beat.
  - stall_cnt increments, saturating at 255.
  - If TIMEOUT!=0 and stall_cnt reaches TIMEOUT-1 with no beat this cycle: go IDLE and pulse abort on the next cycle.
- Grant loss: gnt_owner=0 in any XFER cycle.
  - That cycle is not a beat: out_valid is forced to 0 and take is 0.
  - Go IDLE and pulse abort.
  - Grant loss takes precedence over both a beat and the timeout.
- DONE lasts one cycle:
  - done_owner=1, out_valid=0.
  - Next state IDLE regardless of grants.
  - A new grant is therefore sampled no earlier than 2 cycles after the last beat, which gives the arbiter time to see req drop.
- Beat counting: beat_cnt is 8 bits wide.
  - BURST_LEN=1: every beat is last; out_last=1 throughout XFER.
- Data stability: out_data is not registered. The client holds data_n stable while valid_n=1 and take_n=0.
- Reset asserted mid-burst: immediate return to the reset state. No done or abort pulse is issued.
- Owner transition: owner is fixed for the whole burst. A grant change on the non-owner line during XFER is ignored.

Test Plan:
- Reset, then gnt_0=1, valid_0=1, out_ready=1, data_0=0x10..0x13 -> four consecutive beats, out_src=0, out_last only on beat 4 (data 0x13), take_0 high for 4 cycles, done_0 pulse 1 cycle later, then IDLE.
- gnt_1=1, valid_1=1, out_ready toggling 1,0,1,0... -> exactly 4 beats over 7 XFER cycles, take_1 only on ready cycles, data never changes during stalled cycles, done_1 pulses once.
- gnt_0 burst with out_ready=1; gnt_0 dropped after 2 beats -> out_valid forced 0 that cycle, abort pulse 1 cycle, done_0 never asserted, take_0 count=2.
- TIMEOUT=16, gnt_1=1, valid_1=0 held -> after 16 stalled cycles FSM returns to IDLE, abort pulses once, out_valid never 1.
- gnt_0=gnt_1=1 simultaneously in IDLE -> out_src=0, only take_0 toggles; reset asserted after 1 beat -> all outputs 0 asynchronously, no done/abort.
- BURST_LEN=1 build, gnt_0 with valid and ready -> single beat with out_last=1, done_0 next cycle, next burst's first beat no earlier than 2 cycles after previous last beat.
